serial_rx_sync: RTL and testbench

Serial-link receiver front end for the PHY. It samples the one-bit lane at `clk_32f`, hunts for the comma symbol 0xBC to find byte alignment, and declares the link active after a run of aligned commas. It then deserializes MSB-first bytes into 8-bit words with a valid flag. It sits at the far end of the serializer's lane and feeds the clk_4f-side demux chain that restores the four clk_f lanes.

---
 rtl/serial_rx_sync.sv | 97 +++++++++
 tb/tb_serial_rx_sync.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_sync.sv
// rtl/serial_rx_sync.sv - serial lane receiver: comma hunt, byte alignment, MSB-first deserializer
`timescale 1ns/1ps
module serial_rx_sync #(
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter int         COM_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_t     state, state_nxt;
  logic [7:0] sr, sr_next;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] comma_cnt, comma_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, strobe_nxt;
  logic       is_comma, boundary;

  assign sr_next  = {sr[6:0], serial_in};
  assign is_comma = (sr_next == COMMA);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nxt;
  end

  // Once ACTIVE the link stays locked; only reset re-enters the hunt.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    case (state)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_nxt   = 3'd0;
          comma_cnt_nxt = 4'd1;
          state_nxt     = (COM_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nxt = comma_cnt + 4'd1;
            if (comma_cnt + 4'd1 == COM_TARGET) state_nxt = ACTIVE;
          end else begin
            comma_cnt_nxt = 4'd0;
            state_nxt     = SEARCH;
          end
        end
      end
      ACTIVE:  bit_cnt_nxt = bit_cnt + 3'd1;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    data_nxt   = data_out;
    valid_nxt  = valid_out;
    strobe_nxt = 1'b0;
    active     = (state == ACTIVE);
    if (state == ACTIVE && boundary) begin
      data_nxt   = sr_next;
      valid_nxt  = !is_comma;
      strobe_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      comma_cnt   <= 4'd0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      sr          <= sr_next;
      bit_cnt     <= bit_cnt_nxt;
      comma_cnt   <= comma_cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_serial_rx_sync.sv
// tb/tb_serial_rx_sync.sv - scoreboard bench for serial_rx_sync (default and single-comma lock)
`timescale 1ns/1ps
module tb_serial_rx_sync;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_in1 = 1'b0;
  logic [7:0] data_out, data_out1;
  logic       valid_out, valid_out1, byte_strobe, byte_strobe1, active, active1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_strobe = -1;
  int last_strobe1 = -1;
  int t0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_q1[$];

  serial_rx_sync dut (
    .clk_32f(clk_32f), .reset(reset), .serial_in(serial_in),
    .data_out(data_out), .valid_out(valid_out), .byte_strobe(byte_strobe), .active(active)
  );

  serial_rx_sync #(.COMMA(8'hBC), .COM_COUNT(1)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .serial_in(serial_in1),
    .data_out(data_out1), .valid_out(valid_out1), .byte_strobe(byte_strobe1), .active(active1)
  );

  always #5 clk_32f = ~clk_32f;
  always @(posedge clk_32f) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_32f) begin
    logic [8:0] e;
    if (!reset) begin
      last_strobe  = -1;
      last_strobe1 = -1;
    end else begin
      if (byte_strobe) begin
        check("strobe_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data", data_out, e[7:0]);
          check("valid", valid_out, e[8]);
        end
        if (last_strobe >= 0) check("strobe_spacing", cyc - last_strobe, 8);
        last_strobe = cyc;
      end
      if (byte_strobe1) begin
        check("strobe1_pending", exp_q1.size() > 0, 1);
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check("data1", data_out1, e[7:0]);
          check("valid1", valid_out1, e[8]);
        end
        if (last_strobe1 >= 0) check("strobe1_spacing", cyc - last_strobe1, 8);
        last_strobe1 = cyc;
      end
    end
  end

  task automatic send_bit(input logic b, input logic lane1);
    @(negedge clk_32f);
    if (lane1) serial_in1 = b;
    else       serial_in  = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lane1 = 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(b[i], lane1);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic lane1 = 1'b0);
    if (lane1) exp_q1.push_back({b != 8'hBC, b});
    else       exp_q.push_back({b != 8'hBC, b});
    send_byte(b, lane1);
  endtask

  task automatic lock_edge(input string tag);
    check({tag, "_before"}, active, 0);
    @(posedge clk_32f);
    #1;
    check(tag, active, 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_32f);
    reset = 1'b0;
    serial_in = 1'b0;
    serial_in1 = 1'b0;
    repeat (n) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic finish_test();
    repeat (2) @(negedge clk_32f);
    check("drain", exp_q.size(), 0);
    check("drain1", exp_q1.size(), 0);
    do_reset(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_32f);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 0);
    check("rst_strobe", byte_strobe, 0);
    check("rst_active", active, 0);
    check("rst_active1", active1, 0);
    @(negedge clk_32f);
    reset = 1'b1;

    // lock from an arbitrary bit phase
    repeat (3) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_byte(8'hBC);
    @(posedge clk_32f);
    #1;
    t0 = cyc;
    check("lock_c1", active, 0);
    for (int i = 0; i < 2; i++) begin
      send_byte(8'hBC);
      check("lock_early", active, 0);
    end
    send_byte(8'hBC);
    lock_edge("lock_rise");
    check("lock_latency", cyc - t0, 24);
    expect_byte(8'hFF);
    expect_byte(8'hEE);
    expect_byte(8'hDD);
    expect_byte(8'hCC);

    // fill symbol while active, then a comma straddling a byte boundary
    expect_byte(8'hBC);
    expect_byte(8'h77);
    expect_byte(8'hBC);
    expect_byte(8'h0B);
    expect_byte(8'hC0);

    // reset four bits into a byte
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("pre_rst_data", data_out, 8'hC0);
    check("pre_rst_valid", valid_out, 1);
    check("pre_rst_active", active, 1);
    #2 reset = 1'b0;
    #1;
    check("async_data", data_out, 8'h00);
    check("async_valid", valid_out, 0);
    check("async_strobe", byte_strobe, 0);
    check("async_active", active, 0);
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      check("relock_early", active, 0);
    end
    send_byte(8'hBC);
    lock_edge("relock_rise");
    expect_byte(8'h5A);
    finish_test();

    // broken comma run
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h3A);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      check("broken_early", active, 0);
    end
    send_byte(8'hBC);
    lock_edge("broken_rise");
    expect_byte(8'h55);
    finish_test();

    // single-comma lock on the COM_COUNT=1 instance
    send_byte(8'hBC, 1'b1);
    check("single_before", active1, 0);
    @(posedge clk_32f);
    #1;
    check("single_rise", active1, 1);
    check("single_other_idle", active, 0);
    expect_byte(8'h12, 1'b1);
    finish_test();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
